// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program counter with redirect, stall and a circular
//               return-address stack for call/return prediction.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               STEP         = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             call,
    input  logic [WIDTH-1:0] call_target,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int               c_ptr_w      = $clog2(RAS_DEPTH);
    localparam int               c_cnt_w      = c_ptr_w + 1;
    localparam logic [WIDTH-1:0] c_step       = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] c_align_mask = ~WIDTH'(STEP - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(RAS_DEPTH);

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   w_pc_next;
    logic [WIDTH-1:0]   w_seq_pc;
    logic [WIDTH-1:0]   r_stack [RAS_DEPTH];
    logic [c_ptr_w-1:0] r_sp;
    logic [c_ptr_w-1:0] w_top_idx;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;
    logic               w_ovf;
    logic               w_unf;
    logic               r_ovf;
    logic               r_unf;
    logic               w_empty;
    logic               w_full;

    assign w_seq_pc  = r_pc + c_step;
    // r_sp points at the next free slot, so the top entry sits one below it
    assign w_top_idx = r_sp - c_ptr_one;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_ovf        = 1'b0;
        w_unf        = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_next = RUN;
            end
            RUN: begin
                w_state_next = RUN;
                if (redirect) begin
                    w_pc_next = redirect_pc & c_align_mask;
                end else if (stall) begin
                    w_pc_next = r_pc;
                end else if (ret) begin
                    if (w_empty) begin
                        w_pc_next = w_seq_pc;
                        w_unf     = 1'b1;
                    end else begin
                        w_pc_next = r_stack[w_top_idx];
                        w_pop     = 1'b1;
                    end
                end else if (call) begin
                    w_pc_next = call_target & c_align_mask;
                    w_push    = 1'b1;
                    w_ovf     = w_full;
                end else begin
                    w_pc_next = w_seq_pc;
                end
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state <= BOOT;
            r_pc    <= RESET_VECTOR;
            r_sp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ovf   <= w_ovf;
            r_unf   <= w_unf;
            if (w_push) begin
                r_sp <= r_sp + c_ptr_one;
                // A push while full overwrites the oldest slot; depth stays saturated
                if (!w_full) begin
                    r_count <= r_count + c_cnt_one;
                end
            end else if (w_pop) begin
                r_sp    <= w_top_idx;
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_sp] <= w_seq_pc;
        end
    end

    assign pc            = r_pc;
    assign pc_valid      = (r_state == RUN);
    assign ras_empty     = w_empty;
    assign ras_full      = w_full;
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Scoreboard bench for pc_unit (WIDTH=32, STEP=4, RAS_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        call = 1'b0;
    logic [31:0] call_target = '0;
    logic        ret = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_overflow;
    logic        ras_underflow;

    int errors = 0;
    int checks = 0;

    // Flags are packed as {pc_valid, ras_empty, ras_full, ras_overflow, ras_underflow}
    logic [31:0] exp_pc [$];
    logic [4:0]  exp_fl [$];
    string       exp_nm [$];
    logic [31:0] obs_pc [$];
    logic [4:0]  obs_fl [$];
    logic [31:0] mras   [$];

    pc_unit #(
        .WIDTH       (32),
        .RESET_VECTOR(32'h0),
        .STEP        (4),
        .RAS_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .call         (call),
        .call_target  (call_target),
        .ret          (ret),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic idle();
        stall = 1'b0; redirect = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    task automatic samp(input string nm, input logic [31:0] epc, input logic [4:0] efl);
        exp_nm.push_back(nm); exp_pc.push_back(epc); exp_fl.push_back(efl);
        obs_pc.push_back(pc);
        obs_fl.push_back({pc_valid, ras_empty, ras_full, ras_overflow, ras_underflow});
    endtask

    task automatic cyc(input string nm, input logic [31:0] epc, input logic [4:0] efl);
        @(posedge clk);
        #1;
        samp(nm, epc, efl);
    endtask

    task automatic test_reset();
        logic [31:0] e_pc, o_pc; logic [4:0] e_fl, o_fl; string nm;
        #1 rstn = 1'b1;
        #1 samp("reset_async", 32'h0, 5'b01000);
        cyc("reset_hold", 32'h0, 5'b01000);
        rstn = 1'b0; redirect = 1'b1; redirect_pc = 32'h80; call = 1'b1; call_target = 32'h300;
        cyc("boot_ignores_inputs", 32'h0, 5'b11000);
        idle();
        cyc("seq_1", 32'h4, 5'b11000);
        cyc("seq_2", 32'h8, 5'b11000);
        cyc("seq_3", 32'hC, 5'b11000);
        while (exp_pc.size() != 0) begin
            nm = exp_nm.pop_front(); e_pc = exp_pc.pop_front(); e_fl = exp_fl.pop_front();
            o_pc = obs_pc.pop_front(); o_fl = obs_fl.pop_front();
            checks++;
            if (o_pc !== e_pc || o_fl !== e_fl) begin
                errors++;
                $display("FAIL %s: got pc=%h flags=%b, expected pc=%h flags=%b", nm, o_pc, o_fl, e_pc, e_fl);
            end
        end
    endtask

    task automatic test_stall_redirect();
        logic [31:0] e_pc, o_pc; logic [4:0] e_fl, o_fl; string nm;
        cyc("reach_0x10", 32'h10, 5'b11000);
        stall = 1'b1;
        cyc("stall_1", 32'h10, 5'b11000);
        cyc("stall_2", 32'h10, 5'b11000);
        redirect = 1'b1; redirect_pc = 32'h203;
        cyc("redirect_over_stall", 32'h200, 5'b11000);
        redirect = 1'b0; ret = 1'b1;
        cyc("stall_blocks_underflow", 32'h200, 5'b11000);
        idle();
        while (exp_pc.size() != 0) begin
            nm = exp_nm.pop_front(); e_pc = exp_pc.pop_front(); e_fl = exp_fl.pop_front();
            o_pc = obs_pc.pop_front(); o_fl = obs_fl.pop_front();
            checks++;
            if (o_pc !== e_pc || o_fl !== e_fl) begin
                errors++;
                $display("FAIL %s: got pc=%h flags=%b, expected pc=%h flags=%b", nm, o_pc, o_fl, e_pc, e_fl);
            end
        end
    endtask

    task automatic test_call_ret();
        logic [31:0] e_pc, o_pc; logic [4:0] e_fl, o_fl; string nm;
        redirect = 1'b1; redirect_pc = 32'h40;
        cyc("redirect_0x40", 32'h40, 5'b11000);
        redirect = 1'b0; call = 1'b1; call_target = 32'h100;
        cyc("call_0x100", 32'h100, 5'b10000);
        call = 1'b0;
        cyc("callee_seq_1", 32'h104, 5'b10000);
        cyc("callee_seq_2", 32'h108, 5'b10000);
        ret = 1'b1;
        cyc("return_0x44", 32'h44, 5'b11000);
        idle();
        while (exp_pc.size() != 0) begin
            nm = exp_nm.pop_front(); e_pc = exp_pc.pop_front(); e_fl = exp_fl.pop_front();
            o_pc = obs_pc.pop_front(); o_fl = obs_fl.pop_front();
            checks++;
            if (o_pc !== e_pc || o_fl !== e_fl) begin
                errors++;
                $display("FAIL %s: got pc=%h flags=%b, expected pc=%h flags=%b", nm, o_pc, o_fl, e_pc, e_fl);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] e_pc, o_pc, cur, tgt; logic [4:0] e_fl, o_fl; string nm;
        redirect = 1'b1; redirect_pc = 32'h2000;
        cyc("redirect_0x2000", 32'h2000, 5'b11000);
        redirect = 1'b0;
        cur = 32'h2000;
        mras.delete();
        for (int k = 1; k <= 5; k++) begin
            tgt = 32'h1000 + 32'h100 * (k - 1);
            call = 1'b1;
            call_target = (k == 1) ? (tgt | 32'h3) : tgt;
            mras.push_back(cur + 32'h4);
            if (mras.size() > 4) void'(mras.pop_front());
            cur = tgt;
            cyc($sformatf("call_%0d", k), cur, {1'b1, 1'b0, k >= 4, k == 5, 1'b0});
        end
        call = 1'b0; ret = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cur = mras.pop_back();
            cyc($sformatf("ret_%0d", k), cur, {1'b1, mras.size() == 0, 3'b000});
        end
        cur = cur + 32'h4;
        cyc("ret_underflow", cur, 5'b11001);
        ret = 1'b0;
        cur = cur + 32'h4;
        cyc("underflow_one_cycle", cur, 5'b11000);
        while (exp_pc.size() != 0) begin
            nm = exp_nm.pop_front(); e_pc = exp_pc.pop_front(); e_fl = exp_fl.pop_front();
            o_pc = obs_pc.pop_front(); o_fl = obs_fl.pop_front();
            checks++;
            if (o_pc !== e_pc || o_fl !== e_fl) begin
                errors++;
                $display("FAIL %s: got pc=%h flags=%b, expected pc=%h flags=%b", nm, o_pc, o_fl, e_pc, e_fl);
            end
        end
    endtask

    task automatic test_wrap_conflict();
        logic [31:0] e_pc, o_pc; logic [4:0] e_fl, o_fl; string nm;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc("redirect_top", 32'hFFFF_FFFC, 5'b11000);
        redirect = 1'b0;
        cyc("wrap_to_0", 32'h0, 5'b11000);
        call = 1'b1; call_target = 32'h300;
        cyc("call_a", 32'h300, 5'b10000);
        call_target = 32'h500;
        cyc("call_b", 32'h500, 5'b10000);
        ret = 1'b1; call_target = 32'h700;
        cyc("call_ret_pops", 32'h304, 5'b10000);
        call = 1'b0;
        cyc("ret_last_entry", 32'h4, 5'b11000);
        idle();
        while (exp_pc.size() != 0) begin
            nm = exp_nm.pop_front(); e_pc = exp_pc.pop_front(); e_fl = exp_fl.pop_front();
            o_pc = obs_pc.pop_front(); o_fl = obs_fl.pop_front();
            checks++;
            if (o_pc !== e_pc || o_fl !== e_fl) begin
                errors++;
                $display("FAIL %s: got pc=%h flags=%b, expected pc=%h flags=%b", nm, o_pc, o_fl, e_pc, e_fl);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] e_pc, o_pc; logic [4:0] e_fl, o_fl; string nm;
        call = 1'b1; call_target = 32'h800;
        cyc("fill_1", 32'h800, 5'b10000);
        call_target = 32'h900;
        cyc("fill_2", 32'h900, 5'b10000);
        call_target = 32'hA00;
        cyc("fill_3", 32'hA00, 5'b10000);
        call = 1'b0;
        #2 rstn = 1'b1;
        #1 samp("async_reset_mid", 32'h0, 5'b01000);
        #1 rstn = 1'b0;
        #1 samp("released_boot", 32'h0, 5'b01000);
        cyc("first_run", 32'h0, 5'b11000);
        cyc("run_seq", 32'h4, 5'b11000);
        ret = 1'b1;
        cyc("ras_discarded", 32'h8, 5'b11001);
        ret = 1'b0;
        cyc("after_underflow", 32'hC, 5'b11000);
        while (exp_pc.size() != 0) begin
            nm = exp_nm.pop_front(); e_pc = exp_pc.pop_front(); e_fl = exp_fl.pop_front();
            o_pc = obs_pc.pop_front(); o_fl = obs_fl.pop_front();
            checks++;
            if (o_pc !== e_pc || o_fl !== e_fl) begin
                errors++;
                $display("FAIL %s: got pc=%h flags=%b, expected pc=%h flags=%b", nm, o_pc, o_fl, e_pc, e_fl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall_redirect();
        test_call_ret();
        test_overflow();
        test_wrap_conflict();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32: PC width in bits.
REQ-002 The block SHALL provide parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-003 The block SHALL provide parameter STEP, default 4: sequential increment, a power of two.
REQ-004 The block SHALL provide parameter RAS_DEPTH, default 4: return-address-stack entries, a power of two, at least 2.
REQ-005 The block SHALL provide port clk, input, width 1: single clock; all state updates on the rising edge.
REQ-006 The block SHALL provide port rstn, input, width 1: reset, asynchronous and active-high.
REQ-007 The block SHALL provide port stall, input, width 1: hold PC and RAS.
REQ-008 The block SHALL provide port redirect, input, width 1: load redirect_pc.
REQ-009 The block SHALL provide port redirect_pc, input, width WIDTH: redirect target.
REQ-010 The block SHALL provide port call, input, width 1: push the return address and jump to call_target.
REQ-011 The block SHALL provide port call_target, input, width WIDTH: call target.
REQ-012 The block SHALL provide port ret, input, width 1: pop the RAS and jump to the popped address.
REQ-013 The block SHALL provide port pc, output, width WIDTH: current PC, registered.
REQ-014 The block SHALL provide port pc_valid, output, width 1: pc is meaningful this cycle.
REQ-015 The block SHALL provide port ras_empty, output, width 1: RAS count is 0.
REQ-016 The block SHALL provide port ras_full, output, width 1: RAS count equals RAS_DEPTH.
REQ-017 The block SHALL provide port ras_overflow, output, width 1: one-cycle pulse on a push while full.
REQ-018 The block SHALL provide port ras_underflow, output, width 1: one-cycle pulse on a pop while empty.

Function
REQ-019 The state machine SHALL have two states: BOOT and RUN.
REQ-020 BOOT SHALL be entered on reset and SHALL move to RUN on the first clock edge after rstn deasserts.
REQ-021 In BOOT, pc_valid SHALL be 0, all control inputs SHALL be ignored, and pc SHALL hold RESET_VECTOR.
REQ-022 In RUN, pc_valid SHALL be 1, and the first RUN cycle SHALL present pc = RESET_VECTOR.
REQ-023 In RUN, the next PC SHALL be chosen each edge by this priority: redirect > stall > ret > call > sequential.
REQ-024 redirect SHALL load pc with redirect_pc (low log2(STEP) bits forced to 0), SHALL take effect even when stall = 1, and SHALL leave the RAS unchanged.
REQ-025 When stall = 1 and redirect = 0, pc, the RAS contents and the RAS pointer SHALL all hold, and no overflow or underflow pulse SHALL be generated.
REQ-026 Sequential update: pc <= pc + STEP, modulo 2^WIDTH; wrap-around is silent, with no flag.
REQ-027 call: push pc + STEP (mod 2^WIDTH) onto the RAS; pc <= call_target with its low log2(STEP) bits forced to 0.
REQ-028 ret with a non-empty RAS: pop the top entry; pc <= that entry.
REQ-029 ret with an empty RAS: pc <= pc + STEP, RAS unchanged, ras_underflow pulses for 1 cycle.
REQ-030 call with a full RAS: the RAS is circular and the oldest entry is overwritten; count stays RAS_DEPTH; ras_overflow pulses for 1 cycle.
REQ-031 call and ret asserted together: ret SHALL win and call SHALL be ignored, with no push.
REQ-032 ras_empty and ras_full SHALL be decoded from a registered count of width log2(RAS_DEPTH)+1.
REQ-033 ras_overflow and ras_underflow SHALL be registered and SHALL appear in the cycle after the triggering edge.
REQ-034 The latency from an input to the pc change SHALL be one edge; pc SHALL never change combinationally.

Reset
REQ-035 Asserting rstn SHALL immediately, without waiting for clk, set: pc = RESET_VECTOR, pc_valid = 0, RAS count = 0, ras_empty = 1, ras_full = 0, ras_overflow = 0, ras_underflow = 0, state = BOOT.
REQ-036 Reset asserted mid-operation SHALL discard all RAS contents and any pending pulse.
REQ-037 RAS storage data SHALL NOT be reset; only the pointer and count are reset.

Verification
REQ-038 The bench SHALL cover reset sequencing: rstn = 1, then release; with WIDTH = 32 and RESET_VECTOR = 0, the first edge gives pc_valid = 1, pc = 0, and after 3 more edges pc = 12.
REQ-039 The bench SHALL cover stall and redirect together: at pc = 0x10, with stall = 1 for 2 cycles pc stays 0x10; with stall = 1 and redirect = 1 and redirect_pc = 0x203, the next pc = 0x200.
REQ-040 The bench SHALL cover call and return: at pc = 0x40, call with call_target = 0x100 gives pc = 0x100, ras_empty = 0; 2 sequential cycles give pc = 0x108; ret then gives pc = 0x44, ras_empty = 1.
REQ-041 The bench SHALL cover overflow: with RAS_DEPTH = 4, 5 calls give ras_overflow = 1 after the 5th only; 4 rets then return addresses 5 through 2 in LIFO order, and a 5th ret gives ras_underflow = 1 and sequential pc.
REQ-042 The bench SHALL cover wrap and conflicts: pc = 0xFFFFFFFC sequential gives pc = 0; call and ret in the same cycle give a pop only, with count decreased by 1.
REQ-043 The bench SHALL cover asynchronous reset: rstn pulsed between clock edges with 3 RAS entries gives pc = RESET_VECTOR and ras_empty = 1 before the next edge, and pc_valid = 0 for exactly 1 cycle after release.
